// File: rtl/as_gpio_ctrl_pkg.sv
// as_pack: shared constants, register offsets and FSM state type for the GPIO controller
package as_pack;
  localparam int nr_gpios = 16;
  localparam int gpio_addr_width = 6;
  localparam logic [2:0] GPIO_DATA_OUT = 3'd0;
  localparam logic [2:0] GPIO_DIR = 3'd1;
  localparam logic [2:0] GPIO_DATA_IN = 3'd2;
  localparam logic [2:0] GPIO_IRQ_EN = 3'd3;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'd4;
  typedef enum logic [1:0] {GPIO_IDLE, GPIO_ACCESS, GPIO_RESP} gpio_state_t;
endpackage

// File: rtl/as_gpio_sync.sv
// as_gpio_sync: two-flop pad synchronizer with a rising-edge pulse on the synchronized value
module as_gpio_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);
  logic [2:0] s;
  // shift the pad through two sync stages plus one history stage for edge detection
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) s <= '0;
    else s <= {s[1:0], d_i};
  assign q_o = s[1];
  assign rise_o = s[1] & ~s[2];
endmodule

// File: rtl/as_gpio_ctrl.sv
// as_gpio_ctrl: memory-mapped GPIO controller with tri-state pads, edge interrupts and DATA_OUT write strobe
module as_gpio_ctrl
  import as_pack::*;
#(
  parameter int NR_GPIOS = nr_gpios,
  parameter int ADDR_WIDTH = gpio_addr_width,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ack_o,
  output logic                  cs_o,
  output logic                  irq_o,
  inout  wire  [NR_GPIOS-1:0]   gpio_io
);
  gpio_state_t state, next_state;
  logic we_q;
  logic [ADDR_WIDTH-1:3] addr_q;
  logic [NR_GPIOS-1:0] wdata_q, out_q, dir_q, irq_en_q, irq_stat_q, data_in, rise, rd_mux, rd_q, clr;
  logic wr;
  logic unused_bits;
  assign unused_bits = ^{addr_i[2:0], wdata_i[DATA_WIDTH-1:NR_GPIOS]};
  assign wr = state == GPIO_ACCESS && we_q;
  assign clr = wr && addr_q == GPIO_IRQ_STAT ? wdata_q : '0;
  assign ack_o = state == GPIO_RESP;
  assign cs_o = ack_o && we_q && addr_q == GPIO_DATA_OUT;
  assign rdata_o = DATA_WIDTH'(rd_q);
  for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pad
    assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
    as_gpio_sync u_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (gpio_io[i]),
      .q_o    (data_in[i]),
      .rise_o (rise[i])
    );
  end
  // transaction state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= GPIO_IDLE;
    else state <= next_state;
  // idle waits for a request; access and response each take exactly one cycle
  always_comb begin
    next_state = state == GPIO_IDLE ? (req_i ? GPIO_ACCESS : GPIO_IDLE) :
                 state == GPIO_ACCESS ? GPIO_RESP : GPIO_IDLE;
  end
  // register read multiplexer; unmapped offsets read zero
  always_comb begin
    rd_mux = addr_q == GPIO_DATA_OUT ? out_q :
             addr_q == GPIO_DIR ? dir_q :
             addr_q == GPIO_DATA_IN ? data_in :
             addr_q == GPIO_IRQ_EN ? irq_en_q :
             addr_q == GPIO_IRQ_STAT ? irq_stat_q : '0;
  end
  // latch the request in idle, then perform the write or capture read data in access
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      out_q <= '0;
      dir_q <= '0;
      irq_en_q <= '0;
    end else begin
      if (state == GPIO_IDLE && req_i) begin
        we_q <= we_i;
        addr_q <= addr_i[ADDR_WIDTH-1:3];
        wdata_q <= wdata_i[NR_GPIOS-1:0];
      end
      if (state == GPIO_ACCESS) rd_q <= we_q ? '0 : rd_mux;
      if (wr && addr_q == GPIO_DATA_OUT) out_q <= wdata_q;
      if (wr && addr_q == GPIO_DIR) dir_q <= wdata_q;
      if (wr && addr_q == GPIO_IRQ_EN) irq_en_q <= wdata_q;
    end
  // sticky edge status with write-one-to-clear, a coincident edge wins; irq follows one cycle later
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      irq_stat_q <= '0;
      irq_o <= 1'b0;
    end else begin
      irq_stat_q <= (irq_stat_q & ~clr) | rise;
      irq_o <= |(irq_stat_q & irq_en_q);
    end
endmodule

// File: tb/tb_as_gpio_ctrl.sv
// tb_as_gpio_ctrl: directed self-checking bench for the GPIO controller
module tb_as_gpio_ctrl;
  logic clk, rst, req, we;
  logic [5:0] addr;
  logic [63:0] wdata, rdata, rd;
  logic ack, cs, irq, c;
  logic [15:0] ext_en, ext_val, g;
  wire [15:0] gpio;
  int checks, failures;

  as_gpio_ctrl dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .ack_o   (ack),
    .cs_o    (cs),
    .irq_o   (irq),
    .gpio_io (gpio)
  );

  for (genvar i = 0; i < 16; i++) begin : g_ext
    assign gpio[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic w, input logic [5:0] a, input logic [63:0] d,
                     output logic [63:0] r, output logic s, output logic [15:0] p);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 8);
    chk({tag, "_ack_latency"}, 64'(n), 64'd2);
    r = rdata; s = cs; p = gpio;
    req = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ack_one_cycle"}, {63'd0, ack}, 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    ext_en = '0; ext_val = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset_ack", {63'd0, ack}, 64'd0);
    chk("reset_cs", {63'd0, cs}, 64'd0);
    chk("reset_irq", {63'd0, irq}, 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    bus("dir_ffff", 1'b1, 6'h08, 64'hFFFF, rd, c, g);
    chk("dir_write_cs", {63'd0, c}, 64'd0);
    bus("out_1", 1'b1, 6'h00, 64'hDEAD_0000_0000_0001, rd, c, g);
    chk("out_1_cs", {63'd0, c}, 64'd1);
    chk("out_1_pads", {48'd0, g}, 64'h0001);
    bus("out_5", 1'b1, 6'h00, 64'h5, rd, c, g);
    chk("out_5_cs", {63'd0, c}, 64'd1);
    chk("out_5_pads", {48'd0, g}, 64'h0005);

    bus("dir_00ff", 1'b1, 6'h08, 64'h00FF, rd, c, g);
    chk("dir_00ff_cs", {63'd0, c}, 64'd0);
    ext_en = 16'hFF00; ext_val = 16'hA500;
    repeat (3) @(posedge clk);
    bus("rd_in", 1'b0, 6'h10, 64'h0, rd, c, g);
    chk("data_in", rd, 64'h0000_0000_0000_A505);

    bus("stat_clr_all", 1'b1, 6'h20, 64'hFFFF, rd, c, g);
    bus("rd_stat0", 1'b0, 6'h20, 64'h0, rd, c, g);
    chk("stat_cleared", rd, 64'h0);
    bus("irq_en", 1'b1, 6'h18, 64'h0100, rd, c, g);
    chk("irq_idle", {63'd0, irq}, 64'd0);
    @(negedge clk) ext_val[8] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) ext_val[8] = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("irq_lag", {63'd0, irq}, 64'd0);
    @(posedge clk);
    #1 chk("irq_set", {63'd0, irq}, 64'd1);
    bus("rd_stat1", 1'b0, 6'h20, 64'h0, rd, c, g);
    chk("stat_bit8", rd, 64'h0100);
    bus("w1c", 1'b1, 6'h20, 64'h0100, rd, c, g);
    chk("irq_after_w1c", {63'd0, irq}, 64'd0);
    bus("rd_stat2", 1'b0, 6'h20, 64'h0, rd, c, g);
    chk("stat_after_w1c", rd, 64'h0);
    @(negedge clk) ext_val[8] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) ext_val[8] = 1'b1;
    bus("w1c_race", 1'b1, 6'h20, 64'h0100, rd, c, g);
    bus("rd_stat3", 1'b0, 6'h20, 64'h0, rd, c, g);
    chk("set_wins", rd, 64'h0100);
    chk("irq_after_race", {63'd0, irq}, 64'd1);

    bus("w_in", 1'b1, 6'h10, 64'hFFFF, rd, c, g);
    chk("w_in_cs", {63'd0, c}, 64'd0);
    bus("w_30", 1'b1, 6'h30, 64'hFFFF, rd, c, g);
    chk("w_30_cs", {63'd0, c}, 64'd0);
    bus("rd_out", 1'b0, 6'h00, 64'h0, rd, c, g);
    chk("out_kept", rd, 64'h0005);
    bus("rd_dir", 1'b0, 6'h08, 64'h0, rd, c, g);
    chk("dir_kept", rd, 64'h00FF);
    bus("rd_en", 1'b0, 6'h18, 64'h0, rd, c, g);
    chk("en_kept", rd, 64'h0100);
    bus("rd_30", 1'b0, 6'h30, 64'h0, rd, c, g);
    chk("unused_30", rd, 64'h0);
    bus("rd_28", 1'b0, 6'h28, 64'h0, rd, c, g);
    chk("unused_28", rd, 64'h0);

    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 6'h00; wdata = 64'h00FF;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("abort_ack", {63'd0, ack}, 64'd0);
    chk("abort_cs", {63'd0, cs}, 64'd0);
    chk("abort_irq", {63'd0, irq}, 64'd0);
    req = 1'b0;
    @(posedge clk);
    #1 chk("abort_no_ack", {63'd0, ack}, 64'd0);
    @(negedge clk);
    rst = 1'b0; ext_en = 16'hFFFF; ext_val = 16'h1234;
    repeat (3) @(posedge clk);
    bus("rd_out_rst", 1'b0, 6'h00, 64'h0, rd, c, g);
    chk("out_after_abort", rd, 64'h0);
    bus("rd_dir_rst", 1'b0, 6'h08, 64'h0, rd, c, g);
    chk("dir_after_abort", rd, 64'h0);
    bus("rd_in_rst", 1'b0, 6'h10, 64'h0, rd, c, g);
    chk("pads_released", rd, 64'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
